ext_pipe: RTL and testbench
===========================

EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter DW, 32, datapath/output width in bits; SHALL be a multiple of 16 and at least 32.
REQ-002 Parameter IMM_W, 16, immediate field width.
REQ-003 Parameter CNT_W, 8, error-counter width.
REQ-004 Derived OFFW = log2(DW/8), the byte-offset width.
REQ-005 clk  input  1  system clock, rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  upstream item valid.
REQ-008 in_ready  output  1  block can accept an item.
REQ-009 in_mode  input  3  extension mode (REQ-014).
REQ-010 in_imm  input  IMM_W  immediate operand.
REQ-011 in_word  input  DW  memory word for load modes.
REQ-012 in_off  input  OFFW  byte offset within in_word.
REQ-013 Output ports, each one per line:
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DW  extended result.
- out_err  output  1  misaligned access flag for this item.
- err_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  CNT_W  saturating count of errored items delivered.

Function
REQ-014 in_mode encoding SHALL be:
- 0 SIGN: sign-extend imm to DW.
- 1 ZERO: zero-extend imm to DW.
- 2 HIGH: {imm, (DW-IMM_W) zeros}.
- 3 LB: sign-extend byte in_off.
- 4 LBU: zero-extend byte in_off.
- 5 LH: sign-extend halfword at in_off.
- 6 LHU: zero-extend halfword at in_off.
- 7 LW: in_word passed through unchanged.
REQ-015 Byte k SHALL be in_word[8k+7:8k], little-endian; halfword at in_off SHALL be in_word[8*off+15:8*off].
REQ-016 Misalignment: LH/LHU with in_off[0]=1, or LW with in_off[1:0]!=0 (DW=32) / in_off!=0 (DW>32), SHALL give out_data=0, out_err=1.
- All other cases SHALL give out_err=0.
- Modes 0-4 never err; in_off is ignored for modes 0-2.
REQ-017 The result SHALL be computed combinationally at acceptance and registered; no input is sampled after acceptance.
REQ-018 Handshake:
- An item transfers in when in_valid&&in_ready.
- An item transfers out when out_valid&&out_ready.
- out_data/out_err SHALL hold stable while out_valid&&!out_ready.
REQ-019 Storage SHALL be an output register plus one skid register (2 entries total).
REQ-020 in_ready SHALL be driven directly from a flop and equal !skid_valid.
REQ-021 Latency SHALL be 1 cycle: an item accepted at edge N with the output register empty or draining SHALL present out_valid at edge N.
REQ-022 Throughput SHALL be 1 item/cycle while out_ready=1.
REQ-023 Input accepted while the output is stalled SHALL go to the skid register; in_ready SHALL be 0 from the next cycle.
REQ-024 When the output drains with skid full, skid SHALL move to the output register and in_ready SHALL return to 1 the next cycle.
REQ-025 Simultaneous in-transfer and out-transfer with skid empty SHALL load the output register directly.
REQ-026 Order SHALL be strictly FIFO; no item is dropped or duplicated.
REQ-027 err_cnt SHALL increment by 1 on each out-transfer with out_err=1 and saturate at 2^CNT_W-1.
REQ-028 err_clr SHALL set err_cnt to 0 on the next edge and SHALL take priority over a simultaneous increment.

Reset
REQ-029 reset_n=0 SHALL immediately force out_valid=0, out_data=0, out_err=0, skid_valid=0, in_ready=1 and err_cnt=0.
REQ-030 Reset mid-operation SHALL discard both buffered items.
REQ-031 The first acceptance SHALL occur on the first rising edge after reset_n deasserts with in_valid=1.

Verification
REQ-032 The bench SHALL cover the following scenarios (DW=32):
- Modes 0/1/2, imm=16'h8001, out_ready=1 -> out_data 32'hFFFF8001 / 32'h00008001 / 32'h80010000, each 1 cycle after acceptance, back-to-back.
- in_word=32'h80FF7F01, LB/LBU off=2 -> 32'hFFFFFFFF / 32'h000000FF; LH off=2 -> 32'hFFFF80FF; LHU off=0 -> 32'h00007F01.
- LH off=1 and LW off=2 -> out_data=0, out_err=1; err_cnt increments 0->1->2 on delivery.
- Hold out_ready=0, offer 3 items -> 2 accepted, in_ready=0 from the cycle after the 2nd; release -> items delivered in order, 3rd accepted.
- CNT_W=2, 5 errored items -> err_cnt saturates at 3; err_clr together with an errored delivery -> err_cnt=0.
- Assert reset_n=0 with both entries full -> out_valid=0 and in_ready=1 asynchronously, err_cnt=0.

Source files
------------

// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe.
// Upstream:   in_valid/in_ready handshake with in_mode, in_imm, in_word, in_off.
// Downstream: out_valid/out_ready handshake with out_data, out_err.
// Error side: err_clr request, err_cnt saturating count.
// master: the side that feeds items and consumes results.
// slave:  the ext_pipe block itself.
interface ext_pipe_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned IMM_W = 16,
  parameter int unsigned CNT_W = 8
) ();
  localparam int unsigned OFFW = $clog2(DW / 8);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_mode;
  logic [IMM_W-1:0] in_imm;
  logic [DW-1:0]    in_word;
  logic [OFFW-1:0]  in_off;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             out_err;
  logic             err_clr;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, in_mode, in_imm, in_word, in_off, out_ready, err_clr,
    input  in_ready, out_valid, out_data, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_mode, in_imm, in_word, in_off, out_ready, err_clr,
    output in_ready, out_valid, out_data, out_err, err_cnt
  );
endinterface

// File: rtl/ext_pipe.sv
// Immediate / load-data extension stage with a 2-entry elastic buffer.
// Each accepted item is extended combinationally (sign/zero/high immediate, or a
// byte/halfword/word picked from in_word at in_off) and registered, giving one cycle
// of latency and full throughput. A skid register absorbs one item while the output
// is stalled so that in_ready can come straight from a flop.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - ext_pipe_if slave modport (in/out handshakes, err_clr, err_cnt)
module ext_pipe #(
  parameter int unsigned DW    = 32,
  parameter int unsigned IMM_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic        clk,
  input logic        reset_n,
  ext_pipe_if.slave  bus
);
  localparam logic [2:0] ModeSign = 3'd0;
  localparam logic [2:0] ModeZero = 3'd1;
  localparam logic [2:0] ModeHigh = 3'd2;
  localparam logic [2:0] ModeLb   = 3'd3;
  localparam logic [2:0] ModeLbu  = 3'd4;
  localparam logic [2:0] ModeLh   = 3'd5;
  localparam logic [2:0] ModeLhu  = 3'd6;
  localparam logic [2:0] ModeLw   = 3'd7;

  // Extension of the item currently offered on the input.
  logic [DW-1:0] shifted;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [DW-1:0] ext_data;
  logic          ext_err;

  always_comb begin
    // Bring the addressed byte/halfword down to bit 0 (little-endian).
    shifted  = bus.in_word >> {bus.in_off, 3'b000};
    sel_byte = shifted[7:0];
    sel_half = shifted[15:0];
    ext_data = '0;
    ext_err  = 1'b0;
    case (bus.in_mode)
      ModeSign: ext_data = {{(DW-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};
      ModeZero: ext_data = {{(DW-IMM_W){1'b0}}, bus.in_imm};
      ModeHigh: ext_data = {bus.in_imm, {(DW-IMM_W){1'b0}}};
      ModeLb:   ext_data = {{(DW-8){sel_byte[7]}}, sel_byte};
      ModeLbu:  ext_data = {{(DW-8){1'b0}}, sel_byte};
      ModeLh: begin
        if (bus.in_off[0]) ext_err  = 1'b1;
        else               ext_data = {{(DW-16){sel_half[15]}}, sel_half};
      end
      ModeLhu: begin
        if (bus.in_off[0]) ext_err  = 1'b1;
        else               ext_data = {{(DW-16){1'b0}}, sel_half};
      end
      ModeLw: begin
        // A full word is only aligned at offset 0 for any legal DW.
        if (bus.in_off != '0) ext_err  = 1'b1;
        else                  ext_data = bus.in_word;
      end
      default: ext_data = '0;
    endcase
  end

  // Output register, skid register, registered in_ready, error counter.
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [DW-1:0]    skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic accept;
  logic deliver;

  assign accept  = bus.in_valid && in_ready_q;
  assign deliver = out_valid_q && bus.out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;

    if (!out_valid_q || deliver) begin
      // Output slot frees this edge: refill from skid first to keep FIFO order.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = ext_data;
        out_err_d   = ext_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new item in the skid register.
      skid_valid_d = 1'b1;
      skid_data_d  = ext_data;
      skid_err_d   = ext_err;
    end

    in_ready_d = !skid_valid_d;
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.err_clr) begin
      err_cnt_d = '0;
    end else if (deliver && out_err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      err_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: directed vectors, scoreboard queue filled at acceptance and
// drained by a monitor on each output transfer. A second instance with CNT_W=2
// exercises counter saturation and clear priority.
module tb_ext_pipe;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  ext_pipe_if #(.DW(32), .IMM_W(16), .CNT_W(8)) bus1 ();
  ext_pipe_if #(.DW(32), .IMM_W(16), .CNT_W(2)) bus2 ();

  ext_pipe #(.DW(32), .IMM_W(16), .CNT_W(8)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  ext_pipe #(.DW(32), .IMM_W(16), .CNT_W(2)) u_dut_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus1.out_valid && bus1.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_data", bus1.out_data, e.data);
        chk("sb_err", bus1.out_err, e.err);
      end
    end
  end

  // Offer one item; push its expectation when it is about to be accepted.
  // Returns #1 after the accepting edge with in_valid dropped.
  task automatic send(input logic [2:0] mode, input logic [15:0] imm, input logic [31:0] word,
                      input logic [1:0] off, input logic [31:0] exp_d, input logic exp_e);
    int n;
    n = 0;
    bus1.in_mode  = mode;
    bus1.in_imm   = imm;
    bus1.in_word  = word;
    bus1.in_off   = off;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    while (!bus1.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      chk("accept_timeout", bus1.in_ready, 1);
      bus1.in_valid = 1'b0;
    end else begin
      sb_q.push_back('{data: exp_d, err: exp_e});
      @(posedge clk);
      #1;
      bus1.in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_mode = '0; bus1.in_imm = '0; bus1.in_word = '0;
    bus1.in_off = '0; bus1.out_ready = 1'b1; bus1.err_clr = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_mode = 3'd5; bus2.in_imm = '0;
    bus2.in_word = 32'h1234_5678; bus2.in_off = 2'd1; bus2.out_ready = 1'b1;
    bus2.err_clr = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus1.out_valid, 0);
    chk("rst_out_data", bus1.out_data, 0);
    chk("rst_out_err", bus1.out_err, 0);
    chk("rst_in_ready", bus1.in_ready, 1);
    chk("rst_err_cnt", bus1.err_cnt, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Immediate modes, back-to-back, one cycle latency.
    send(3'd0, 16'h8001, 32'h0, 2'd0, 32'hFFFF_8001, 1'b0);
    chk("lat_sign_valid", bus1.out_valid, 1);
    chk("lat_sign_data", bus1.out_data, 32'hFFFF_8001);
    send(3'd1, 16'h8001, 32'h0, 2'd0, 32'h0000_8001, 1'b0);
    chk("lat_zero_data", bus1.out_data, 32'h0000_8001);
    send(3'd2, 16'h8001, 32'h0, 2'd3, 32'h8001_0000, 1'b0);
    chk("lat_high_data", bus1.out_data, 32'h8001_0000);

    // Loads from a little-endian word.
    send(3'd3, 16'h0, 32'h80FF_7F01, 2'd2, 32'hFFFF_FFFF, 1'b0);
    send(3'd4, 16'h0, 32'h80FF_7F01, 2'd2, 32'h0000_00FF, 1'b0);
    send(3'd5, 16'h0, 32'h80FF_7F01, 2'd2, 32'hFFFF_80FF, 1'b0);
    send(3'd6, 16'h0, 32'h80FF_7F01, 2'd0, 32'h0000_7F01, 1'b0);
    send(3'd3, 16'h0, 32'h80FF_7F01, 2'd1, 32'h0000_007F, 1'b0);
    send(3'd7, 16'h0, 32'h80FF_7F01, 2'd0, 32'h80FF_7F01, 1'b0);

    // Misaligned accesses and error counting on delivery.
    send(3'd5, 16'h0, 32'h80FF_7F01, 2'd1, 32'h0, 1'b1);
    chk("err_cnt_0", bus1.err_cnt, 0);
    send(3'd7, 16'h0, 32'h80FF_7F01, 2'd2, 32'h0, 1'b1);
    chk("err_cnt_1", bus1.err_cnt, 1);
    @(posedge clk);
    #1;
    chk("err_cnt_2", bus1.err_cnt, 2);

    // Stall: two items fill output + skid, third waits.
    bus1.out_ready = 1'b0;
    send(3'd7, 16'h0, 32'h1111_1111, 2'd0, 32'h1111_1111, 1'b0);
    send(3'd7, 16'h0, 32'h2222_2222, 2'd0, 32'h2222_2222, 1'b0);
    chk("stall_in_ready", bus1.in_ready, 0);
    fork
      send(3'd1, 16'h3333, 32'h0, 2'd0, 32'h0000_3333, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("stall_in_ready_held", bus1.in_ready, 0);
        chk("stall_out_valid", bus1.out_valid, 1);
        chk("stall_out_hold", bus1.out_data, 32'h1111_1111);
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_skid_to_out", bus1.out_data, 32'h2222_2222);
        chk("drain_in_ready", bus1.in_ready, 1);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", sb_q.size(), 0);
    chk("drain_out_valid", bus1.out_valid, 0);

    // Saturation with CNT_W=2, then clear against a simultaneous increment.
    bus2.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_cnt_2", bus2.err_cnt, 2);
    repeat (2) @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    chk("sat_cnt_3", bus2.err_cnt, 3);
    @(posedge clk);
    #1;
    chk("sat_cnt_hold", bus2.err_cnt, 3);
    chk("sat_drained", bus2.out_valid, 0);
    bus2.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    chk("clr_pending_err", bus2.out_valid && bus2.out_err, 1);
    bus2.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus2.err_clr = 1'b0;
    chk("clr_priority", bus2.err_cnt, 0);

    // Asynchronous reset with both entries full.
    bus1.out_ready = 1'b0;
    send(3'd7, 16'h0, 32'hAAAA_0001, 2'd0, 32'hAAAA_0001, 1'b0);
    send(3'd7, 16'h0, 32'hAAAA_0002, 2'd0, 32'hAAAA_0002, 1'b0);
    chk("full_in_ready", bus1.in_ready, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", bus1.out_valid, 0);
    chk("arst_in_ready", bus1.in_ready, 1);
    chk("arst_err_cnt", bus1.err_cnt, 0);
    chk("arst_out_data", bus1.out_data, 0);
    sb_q.delete();

    // First acceptance on the first edge after reset release.
    bus1.out_ready = 1'b1;
    bus1.in_mode   = 3'd0;
    bus1.in_imm    = 16'h7FFF;
    bus1.in_off    = 2'd0;
    bus1.in_valid  = 1'b1;
    sb_q.push_back('{data: 32'h0000_7FFF, err: 1'b0});
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    chk("post_rst_valid", bus1.out_valid, 1);
    chk("post_rst_data", bus1.out_data, 32'h0000_7FFF);
    repeat (2) @(posedge clk);
    #1;
    chk("final_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
